// File: rtl/kd_tree_pkg.sv
// -----------------------------------------------------------------------------
// kd_tree_pkg
// Shared declarations for the KD-tree sequencer and the internal-node tree.
//   seq_state_t       : sequencer phase (IDLE, LOAD, SEARCH, DRAIN)
//   KD_PATCH_WIDTH    : default query patch width (5 x 11-bit signed)
//   KD_ADDRESS_WIDTH  : default leaf index width
//   KD_TREE_LATENCY   : default tree pipeline latency in cycles
//   sat_inc32()       : saturating 32-bit increment for statistics counters
// -----------------------------------------------------------------------------
package kd_tree_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SEARCH = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    localparam int unsigned KD_PATCH_WIDTH   = 32'd55;
    localparam int unsigned KD_ADDRESS_WIDTH = 32'd8;
    localparam int unsigned KD_TREE_LATENCY  = 32'd6;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/kd_tree_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// leaf_result_fifo
// Synchronous DEPTH x WIDTH FIFO holding leaf indices in query order.
// The head entry is kept in its own register so the read data is a flop output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored if full and not popping)
//   push_data   : entry to write
//   pop         : remove the head entry (ignored if empty)
//   head_data   : registered copy of the current head entry
//   empty       : no entries stored
//   count       : number of stored entries
// -----------------------------------------------------------------------------
module leaf_result_fifo
    import kd_tree_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd8,
    parameter int unsigned WIDTH = KD_ADDRESS_WIDTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 32'd1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 32'd1)) ? '0 : (ptr + PTR_W'(1));
    endfunction

    // Next-state computation for storage, pointers, occupancy and head register.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != CNT_W'(DEPTH)) || do_pop_s);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A word written into the slot the read pointer lands on becomes the
        // head directly, since the array copy is only visible next cycle.
        if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_data = head_q;
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/kd_tree_sequencer.sv
// -----------------------------------------------------------------------------
// kd_tree_sequencer
// Sequences the KD-tree: loads NUM_NODES internal-node words, then streams
// query patches through the fixed-latency tree and returns leaf indices in
// query order through a credit-guarded result FIFO.
// Optional feature macro: KD_TREE_SEQ_STATS_EN adds query_count/stall_count.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start / flush              : begin a load (IDLE) / end the search phase
//   node_enq / node_full_n     : aggregator node-word handshake
//   tree_load_en / load_done   : tree load enable, end-of-load pulse
//   query_valid/ready/patch    : query input handshake
//   tree_patch/tree_leaf_index : tree datapath interface
//   result_valid/ready/index   : result output handshake
//   busy / stray_node          : not IDLE / sticky node_enq seen outside LOAD
//   query_count / stall_count  : statistics (only with KD_TREE_SEQ_STATS_EN)
// -----------------------------------------------------------------------------
module kd_tree_sequencer
    import kd_tree_pkg::*;
#(
    parameter int unsigned NUM_NODES     = 32'd63,
    parameter int unsigned PATCH_WIDTH   = KD_PATCH_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = KD_ADDRESS_WIDTH,
    parameter int unsigned TREE_LATENCY  = KD_TREE_LATENCY,
    parameter int unsigned RESULT_DEPTH  = 32'd8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     flush,
    input  logic                     node_enq,
    output logic                     node_full_n,
    output logic                     tree_load_en,
    output logic                     load_done,
    input  logic                     query_valid,
    output logic                     query_ready,
    input  logic [PATCH_WIDTH-1:0]   query_patch,
    output logic [PATCH_WIDTH-1:0]   tree_patch,
    input  logic [ADDRESS_WIDTH-1:0] tree_leaf_index,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [ADDRESS_WIDTH-1:0] result_index,
    output logic                     busy,
`ifdef KD_TREE_SEQ_STATS_EN
    output logic [31:0]              query_count,
    output logic [31:0]              stall_count,
`endif
    output logic                     stray_node
);

    localparam int unsigned NODE_CNT_W = $clog2(NUM_NODES + 32'd1);
    // Stage 0 tracks the query sitting in the tree_patch register; the tree
    // latency counts from there, so the index is ready when a 1 leaves the
    // last stage.
    localparam int unsigned VLD_W      = TREE_LATENCY + 32'd1;
    localparam int unsigned INF_W      = $clog2(VLD_W + 32'd1);
    localparam int unsigned FCNT_W     = $clog2(RESULT_DEPTH + 32'd1);

    seq_state_t               state_q, state_d;
    logic [NODE_CNT_W-1:0]    node_cnt_q, node_cnt_d;
    logic [VLD_W-1:0]         vld_q, vld_d;
    logic [PATCH_WIDTH-1:0]   tree_patch_q, tree_patch_d;
    logic                     load_done_q, load_done_d;
    logic                     node_full_n_q, node_full_n_d;
    logic                     tree_load_en_q, tree_load_en_d;
    logic                     busy_q, busy_d;
    logic                     stray_q, stray_d;
`ifdef KD_TREE_SEQ_STATS_EN
    logic [31:0]              query_count_q, query_count_d;
    logic [31:0]              stall_count_q, stall_count_d;
`endif

    logic [INF_W-1:0]         inflight_s;
    logic [31:0]              outstanding_s;
    logic [FCNT_W-1:0]        fifo_count_s;
    logic                     fifo_empty_s;
    logic                     accept_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     start_acc_s;

    // Credit accounting: every accepted, not yet returned query owns one FIFO slot.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < int'(VLD_W); i++) begin
            inflight_s = inflight_s + INF_W'(vld_q[i]);
        end
        outstanding_s = 32'(inflight_s) + 32'(fifo_count_s);
        query_ready   = (state_q == SEARCH) && (outstanding_s < RESULT_DEPTH);
        accept_s      = query_valid && query_ready;
        push_s        = vld_q[VLD_W-1];
        pop_s         = result_valid && result_ready;
        start_acc_s   = (state_q == IDLE) && start;
    end

    // Phase sequencing, node counting, query pipeline tracking and registered outputs.
    always_comb begin
        state_d      = state_q;
        node_cnt_d   = node_cnt_q;
        load_done_d  = 1'b0;
        stray_d      = stray_q || (node_enq && (state_q != LOAD));
        vld_d        = {vld_q[VLD_W-2:0], accept_s};

        if (accept_s) begin
            tree_patch_d = query_patch;
        end else begin
            tree_patch_d = tree_patch_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    node_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (node_enq) begin
                    if (node_cnt_q == NODE_CNT_W'(NUM_NODES - 32'd1)) begin
                        state_d     = SEARCH;
                        load_done_d = 1'b1;
                    end else begin
                        node_cnt_d = node_cnt_q + NODE_CNT_W'(1);
                    end
                end else begin
                    node_cnt_d = node_cnt_q;
                end
            end
            SEARCH: begin
                if (flush) begin
                    state_d = DRAIN;
                end else begin
                    state_d = SEARCH;
                end
            end
            DRAIN: begin
                if ((inflight_s == '0) && fifo_empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        node_full_n_d  = (state_d == LOAD);
        tree_load_en_d = (state_d == LOAD);
        busy_d         = (state_d != IDLE);

`ifdef KD_TREE_SEQ_STATS_EN
        if (start_acc_s) begin
            query_count_d = 32'd0;
            stall_count_d = 32'd0;
        end else begin
            query_count_d = accept_s ? sat_inc32(query_count_q) : query_count_q;
            if ((state_q == SEARCH) && query_valid && !query_ready) begin
                stall_count_d = sat_inc32(stall_count_q);
            end else begin
                stall_count_d = stall_count_q;
            end
        end
`endif
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            node_cnt_q     <= '0;
            vld_q          <= '0;
            tree_patch_q   <= '0;
            load_done_q    <= 1'b0;
            node_full_n_q  <= 1'b0;
            tree_load_en_q <= 1'b0;
            busy_q         <= 1'b0;
            stray_q        <= 1'b0;
`ifdef KD_TREE_SEQ_STATS_EN
            query_count_q  <= 32'd0;
            stall_count_q  <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            node_cnt_q     <= node_cnt_d;
            vld_q          <= vld_d;
            tree_patch_q   <= tree_patch_d;
            load_done_q    <= load_done_d;
            node_full_n_q  <= node_full_n_d;
            tree_load_en_q <= tree_load_en_d;
            busy_q         <= busy_d;
            stray_q        <= stray_d;
`ifdef KD_TREE_SEQ_STATS_EN
            query_count_q  <= query_count_d;
            stall_count_q  <= stall_count_d;
`endif
        end
    end

    leaf_result_fifo #(
        .DEPTH (RESULT_DEPTH),
        .WIDTH (ADDRESS_WIDTH),
        .CNT_W (FCNT_W)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (tree_leaf_index),
        .pop       (pop_s),
        .head_data (result_index),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign result_valid = !fifo_empty_s;
    assign node_full_n  = node_full_n_q;
    assign tree_load_en = tree_load_en_q;
    assign load_done    = load_done_q;
    assign tree_patch   = tree_patch_q;
    assign busy         = busy_q;
    assign stray_node   = stray_q;
`ifdef KD_TREE_SEQ_STATS_EN
    assign query_count  = query_count_q;
    assign stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_kd_tree_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kd_tree_sequencer
// Bench for kd_tree_sequencer. The tree is modelled as a TREE_LATENCY-stage
// delay line whose leaf is patch[7:0]; results are checked against a queue of
// accepted query patches, and query_ready against the outstanding count.
// -----------------------------------------------------------------------------
module tb_kd_tree_sequencer;

    localparam int NN  = 63;
    localparam int PW  = 55;
    localparam int AW  = 8;
    localparam int LAT = 6;
    localparam int RD  = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, flush, node_enq, query_valid, result_ready;
    logic [PW-1:0] query_patch;
    logic [AW-1:0] tree_leaf_index;
    logic          node_full_n, tree_load_en, load_done, query_ready;
    logic          result_valid, busy, stray_node;
    logic [PW-1:0] tree_patch;
    logic [AW-1:0] result_index;
`ifdef KD_TREE_SEQ_STATS_EN
    logic [31:0]   query_count, stall_count;
`endif

    always #5 clk = ~clk;

    kd_tree_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .flush           (flush),
        .node_enq        (node_enq),
        .node_full_n     (node_full_n),
        .tree_load_en    (tree_load_en),
        .load_done       (load_done),
        .query_valid     (query_valid),
        .query_ready     (query_ready),
        .query_patch     (query_patch),
        .tree_patch      (tree_patch),
        .tree_leaf_index (tree_leaf_index),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_index    (result_index),
        .busy            (busy),
`ifdef KD_TREE_SEQ_STATS_EN
        .query_count     (query_count),
        .stall_count     (stall_count),
`endif
        .stray_node      (stray_node)
    );

    // Tree model: fixed-latency delay line, leaf = patch[7:0].
    logic [PW-1:0] tree_pipe [LAT];
    always @(posedge clk) begin
        tree_pipe[0] <= tree_patch;
        for (int i = 1; i < LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
    assign tree_leaf_index = tree_pipe[LAT-1][AW-1:0];

    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] exp_q [$];
    int            n_acc = 0;
    int            n_pop = 0;
    int            ld_pulses;
    int            le_low;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_patch(input logic [7:0] low);
        logic [63:0] r;
        r      = {$urandom(), $urandom()};
        r[7:0] = low;
        return r[PW-1:0];
    endfunction

    // Records handshakes that happen at the coming edge, then advances one cycle.
    task automatic tick();
        if (query_valid && query_ready) begin
            exp_q.push_back(query_patch[AW-1:0]);
            n_acc++;
        end
        if (result_valid && result_ready) begin
            if (exp_q.size() == 0) check_value("sb_extra_result", 64'(result_index), 64'h100);
            else check_value("sb_result_order", 64'(result_index), 64'(exp_q.pop_front()));
            n_pop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_node_full_n"}, 64'(node_full_n), 64'd0);
        check_value({tag, "_tree_load_en"}, 64'(tree_load_en), 64'd0);
        check_value({tag, "_load_done"}, 64'(load_done), 64'd0);
        check_value({tag, "_query_ready"}, 64'(query_ready), 64'd0);
        check_value({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        check_value({tag, "_busy"}, 64'(busy), 64'd0);
        check_value({tag, "_stray_node"}, 64'(stray_node), 64'd0);
        check_value({tag, "_tree_patch"}, 64'(tree_patch), 64'd0);
        check_value({tag, "_result_index"}, 64'(result_index), 64'd0);
    endtask

    task automatic do_load(input int words);
        ld_pulses = 0;
        le_low    = 0;
        start = 1'b1; tick(); start = 1'b0;
        check_value("load_start_node_full_n", 64'(node_full_n), 64'd1);
        check_value("load_start_tree_load_en", 64'(tree_load_en), 64'd1);
        check_value("load_start_busy", 64'(busy), 64'd1);
        for (int i = 0; i < words; i++) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                if (load_done) ld_pulses++;
                if (!tree_load_en) le_low++;
            end
            node_enq = 1'b1; tick(); node_enq = 1'b0;
            if (load_done) ld_pulses++;
            if ((i < NN - 1) && !tree_load_en) le_low++;
        end
    endtask

    task automatic wait_result(input string tag, input int max_cycles, output int k);
        k = 0;
        while (!result_valid && (k < max_cycles)) begin
            tick();
            k++;
        end
        if (!result_valid) check_value({tag, "_timeout"}, 64'(result_valid), 64'd1);
    endtask

    task automatic drain_all(input string tag);
        int guard;
        guard        = 0;
        query_valid  = 1'b0;
        result_ready = 1'b1;
        while ((exp_q.size() != 0) && (guard < 100)) begin
            tick();
            guard++;
        end
        check_value({tag, "_left_over"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, a0, p0;
        logic [PW-1:0] p;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; node_enq = 1'b0;
        query_valid = 1'b0; result_ready = 1'b0; query_patch = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Full load with random gaps.
        do_load(NN);
        check_value("load_done_after_last", 64'(load_done), 64'd1);
        check_value("load_tree_load_en_fall", 64'(tree_load_en), 64'd0);
        check_value("load_node_full_n_fall", 64'(node_full_n), 64'd0);
        check_value("load_en_window", 64'(le_low), 64'd0);
        tick();
        if (load_done) ld_pulses++;
        check_value("load_done_pulses", 64'(ld_pulses), 64'd1);
        check_value("search_query_ready", 64'(query_ready), 64'd1);

        // Extra node word outside LOAD.
        check_value("stray_before", 64'(stray_node), 64'd0);
        node_enq = 1'b1; tick(); node_enq = 1'b0;
        check_value("stray_after", 64'(stray_node), 64'd1);

        // Single query: 7-cycle latency, one-cycle result.
        result_ready = 1'b1;
        p = rand_patch(8'h4F);
        query_patch = p; query_valid = 1'b1;
        a0 = n_acc;
        tick();
        query_valid = 1'b0;
        check_value("single_accepted", 64'(n_acc - a0), 64'd1);
        check_value("single_tree_patch", 64'(tree_patch), 64'(p));
        wait_result("single", 20, k);
        check_value("single_latency", 64'(k), 64'd7);
        check_value("single_index", 64'(result_index), 64'h4F);
        tick();
        check_value("single_valid_one_cycle", 64'(result_valid), 64'd0);
        check_value("tree_patch_hold", 64'(tree_patch), 64'(p));

        // Back-to-back queries.
        a0 = n_acc;
        query_valid = 1'b1;
        query_patch = rand_patch(8'h16); tick();
        query_patch = rand_patch(8'h05); tick();
        query_patch = rand_patch(8'h18); tick();
        query_valid = 1'b0;
        check_value("b2b_accepted", 64'(n_acc - a0), 64'd3);
        wait_result("b2b", 20, k);
        check_value("b2b_r0_valid", 64'(result_valid), 64'd1);
        check_value("b2b_r0", 64'(result_index), 64'd22);
        tick();
        check_value("b2b_r1_valid", 64'(result_valid), 64'd1);
        check_value("b2b_r1", 64'(result_index), 64'd5);
        tick();
        check_value("b2b_r2_valid", 64'(result_valid), 64'd1);
        check_value("b2b_r2", 64'(result_index), 64'd24);
        tick();
        check_value("b2b_done", 64'(result_valid), 64'd0);

        // Backpressure: credit limit of RESULT_DEPTH.
        result_ready = 1'b0;
        query_valid  = 1'b1;
        a0 = n_acc;
        p0 = n_pop;
        repeat (25) begin
            query_patch = rand_patch(8'($urandom()));
            tick();
        end
        check_value("bp_accepted", 64'(n_acc - a0), 64'(RD));
        check_value("bp_query_ready_low", 64'(query_ready), 64'd0);
        drain_all("bp");
        check_value("bp_returned", 64'(n_pop - p0), 64'(RD));
        check_value("bp_empty", 64'(result_valid), 64'd0);

        // Randomized traffic with credit check against outstanding count.
        repeat (300) begin
            query_valid  = 1'($urandom_range(0, 1));
            result_ready = ($urandom_range(0, 3) != 0);
            query_patch  = rand_patch(8'($urandom()));
            check_value("rand_credit", 64'(query_ready), 64'(exp_q.size() < RD));
            tick();
        end
        drain_all("rand");

        // Flush with 3 in flight; accept and flush in the same cycle.
        result_ready = 1'b1;
        p0 = n_pop;
        query_valid = 1'b1;
        query_patch = rand_patch(8'($urandom())); tick();
        query_patch = rand_patch(8'($urandom())); tick();
        query_patch = rand_patch(8'($urandom())); flush = 1'b1; tick();
        query_valid = 1'b0; flush = 1'b0;
        check_value("flush_inflight", 64'(exp_q.size()), 64'd3);
        check_value("drain_query_ready", 64'(query_ready), 64'd0);
        check_value("drain_busy", 64'(busy), 64'd1);
        start = 1'b1; tick(); start = 1'b0;
        check_value("drain_start_ignored", 64'(node_full_n), 64'd0);
        k = 0;
        while (busy && (k < 40)) begin
            tick();
            k++;
        end
        check_value("drain_idle_busy", 64'(busy), 64'd0);
        check_value("drain_returned", 64'(n_pop - p0), 64'd3);
        check_value("drain_left_over", 64'(exp_q.size()), 64'd0);
        check_value("idle_tree_load_en", 64'(tree_load_en), 64'd0);

        // flush in IDLE does nothing.
        flush = 1'b1; tick(); flush = 1'b0;
        check_value("idle_flush_busy", 64'(busy), 64'd0);

        // Reset in the middle of a load.
        do_load(30);
        check_value("partial_no_done", 64'(ld_pulses), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset");
        #2;
        rst_n = 1'b1;
        tick();
        do_load(NN - 1);
        check_value("reload_no_early_done", 64'(ld_pulses), 64'd0);
        check_value("reload_still_loading", 64'(tree_load_en), 64'd1);
        node_enq = 1'b1; tick(); node_enq = 1'b0;
        check_value("reload_done", 64'(load_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
